// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the requester-side handshake and the RAM-side bus of the
// ram_arbiter so the arbiter can take them as one port.
//
// Signals
//   req          per-requester request level
//   we           per-requester write enable (1=write, 0=read)
//   addr         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata        packed write data, same packing
//   done         one-cycle completion pulse to the served requester
//   rd_data      last captured read data, shared by all requesters
//   busy         arbiter is not idle
//   ram_rd       RAM read strobe
//   ram_wr       RAM write strobe
//   ram_addr     RAM address
//   ram_wr_data  RAM write data
//   ram_rd_data  RAM read data
//
// Modports
//   slave   the arbiter's view
//   master  the environment's view (requesters plus the RAM)
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic                      ram_rd;
  logic                      ram_wr;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wr_data;
  logic [DATA_W-1:0]         ram_rd_data;

  modport slave (
    input  req, we, addr, wdata, ram_rd_data,
    output done, rd_data, busy, ram_rd, ram_wr, ram_addr, ram_wr_data
  );

  modport master (
    output req, we, addr, wdata, ram_rd_data,
    input  done, rd_data, busy, ram_rd, ram_wr, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port RAM between NUM_REQ bus masters. Level-held
// requests are granted round-robin; the winner's command is issued as a
// one-cycle rd/wr strobe, read latency is waited out, and a one-cycle done
// pulse goes back to the winner together with any captured read data.
//
// Ports
//   clk_system_i  system clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   bus           ram_arbiter_if.slave: requester handshake and RAM bus
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk_system_i,
  input  logic          reset_n_i,
  ram_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rdData_q, rdData_d;
  logic               busy_q, busy_d;
  logic               ramRd_q, ramRd_d;
  logic               ramWr_q, ramWr_d;
  logic [ADDR_W-1:0]  ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0]  ramWrData_q, ramWrData_d;

  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   candIdx;

  // Round-robin pick: walk from the requester just after the last served
  // one, wrapping around, and take the first active request. The last
  // served requester is visited last, which makes it lowest priority.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pickValid && bus.req[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // Next-state and next-output logic. The RAM-side outputs are computed
  // one cycle early so that, once registered, the strobe is high exactly
  // during ISSUE and done is high exactly during DONE. The address and
  // write data are loaded at grant time and simply held afterwards, so
  // they double as the latched payload.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    we_d        = we_q;
    waitCnt_d   = waitCnt_q;
    done_d      = '0;
    rdData_d    = rdData_q;
    ramRd_d     = 1'b0;
    ramWr_d     = 1'b0;
    ramAddr_d   = ramAddr_q;
    ramWrData_d = ramWrData_q;

    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d   = pickIdx;
          we_d      = bus.we[pickIdx];
          ramAddr_d = bus.addr[pickIdx*ADDR_W +: ADDR_W];
          if (bus.we[pickIdx]) begin
            ramWr_d     = 1'b1;
            ramWrData_d = bus.wdata[pickIdx*DATA_W +: DATA_W];
          end else begin
            ramRd_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end else begin
          waitCnt_d = CNT_W'(RD_LATENCY);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Counter reaching 1 marks the last WAIT cycle: the RAM data is
        // valid now and is captured on this edge.
        if (waitCnt_q == CNT_W'(1)) begin
          rdData_d        = bus.ram_rd_data;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      DONE: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset lands in IDLE with the pointer on
  // the highest index so requester 0 is the first to win, and aborts any
  // transaction in flight without a done pulse.
  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      we_q        <= 1'b0;
      waitCnt_q   <= '0;
      done_q      <= '0;
      rdData_q    <= '0;
      busy_q      <= 1'b0;
      ramRd_q     <= 1'b0;
      ramWr_q     <= 1'b0;
      ramAddr_q   <= '0;
      ramWrData_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      waitCnt_q   <= waitCnt_d;
      done_q      <= done_d;
      rdData_q    <= rdData_d;
      busy_q      <= busy_d;
      ramRd_q     <= ramRd_d;
      ramWr_q     <= ramWr_d;
      ramAddr_q   <= ramAddr_d;
      ramWrData_q <= ramWrData_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.rd_data     = rdData_q;
  assign bus.busy        = busy_q;
  assign bus.ram_rd      = ramRd_q;
  assign bus.ram_wr      = ramWr_q;
  assign bus.ram_addr    = ramAddr_q;
  assign bus.ram_wr_data = ramWrData_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Drives two ram_arbiter instances: dut1 with RD_LATENCY=1 and dut3 with
// RD_LATENCY=3 (used for the reset-during-read case). Each has a small RAM
// model behind it. Expected strobes and done responses are queued when a
// transaction is issued; a negedge monitor per instance pops and compares
// whenever a strobe or done pulse shows up.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  typedef struct {
    int         idx;
    logic [7:0] rd;
  } doneExp_t;

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
  } strbExp_t;

  logic clk = 1'b0;
  logic rst1N;
  logic rst3N;

  logic [3:0]  reqV   [2];
  logic [3:0]  weV    [2];
  logic [31:0] addrV  [2];
  logic [31:0] wdataV [2];
  wire  [3:0]  doneW  [2];

  int nChecks = 0;
  int nFail   = 0;

  doneExp_t doneQ1[$];
  doneExp_t doneQ3[$];
  strbExp_t strbQ1[$];
  strbExp_t strbQ3[$];

  ram_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) ifc1 ();
  ram_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) ifc3 ();

  ram_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut1 (
    .clk_system_i (clk),
    .reset_n_i    (rst1N),
    .bus          (ifc1)
  );

  ram_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut3 (
    .clk_system_i (clk),
    .reset_n_i    (rst3N),
    .bus          (ifc3)
  );

  always #5 clk = ~clk;

  assign ifc1.req   = reqV[0];
  assign ifc1.we    = weV[0];
  assign ifc1.addr  = addrV[0];
  assign ifc1.wdata = wdataV[0];
  assign ifc3.req   = reqV[1];
  assign ifc3.we    = weV[1];
  assign ifc3.addr  = addrV[1];
  assign ifc3.wdata = wdataV[1];
  assign doneW[0]   = ifc1.done;
  assign doneW[1]   = ifc3.done;

  // RAM models: writes land on the strobe edge; reads go through a chain
  // of RD_LATENCY registers starting at the strobe edge.
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] mem3 [256] = '{default: 8'h00};
  logic [7:0] pipe1      = 8'h00;
  logic [7:0] pipe3 [3]  = '{default: 8'h00};

  always @(posedge clk) begin
    if (ifc1.ram_wr) mem1[ifc1.ram_addr] <= ifc1.ram_wr_data;
    if (ifc1.ram_rd) pipe1 <= mem1[ifc1.ram_addr];
  end

  always @(posedge clk) begin
    if (ifc3.ram_wr) mem3[ifc3.ram_addr] <= ifc3.ram_wr_data;
    if (ifc3.ram_rd) pipe3[0] <= mem3[ifc3.ram_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign ifc1.ram_rd_data = pipe1;
  assign ifc3.ram_rd_data = pipe3[2];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expectTxn(input int u, input int idx, input bit w,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] rdExp);
    strbExp_t se;
    doneExp_t de;
    se.wr = w; se.a = a; se.d = d;
    de.idx = idx; de.rd = rdExp;
    if (u == 0) begin
      strbQ1.push_back(se);
      doneQ1.push_back(de);
    end else begin
      strbQ3.push_back(se);
      doneQ3.push_back(de);
    end
  endtask

  // Raises one request and holds it until done is sampled, then drops it.
  // lat counts rising edges from the first one that can sample the
  // request up to and including the edge that samples done.
  task automatic applyStimulus(input int u, input int idx, input bit w,
                               input logic [7:0] a, input logic [7:0] d, output int lat);
    logic seen;
    weV[u][idx]              = w;
    addrV[u][idx*8 +: 8]     = a;
    wdataV[u][idx*8 +: 8]    = d;
    reqV[u][idx]             = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      lat++;
      seen = doneW[u][idx];
    end
    if (!seen) checkOutput($sformatf("done timeout u%0d req%0d", u, idx), 32'(seen), 32'd1);
    #1;
    reqV[u][idx] = 1'b0;
  endtask

  task automatic txn(input int u, input int idx, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] rdExp, input int expLat);
    int lat;
    @(posedge clk);
    #1;
    expectTxn(u, idx, w, a, d, rdExp);
    applyStimulus(u, idx, w, a, d, lat);
    checkOutput($sformatf("latency u%0d req%0d addr %0h", u, idx, a), lat, expLat);
  endtask

  // Scoreboard compare for one instance, run on every falling edge.
  task automatic checkDut(input int u, input logic [3:0] dn, input logic [7:0] rd,
                          input logic bsy, input logic rRd, input logic rWr,
                          input logic [7:0] rA, input logic [7:0] rWd);
    doneExp_t de;
    strbExp_t se;
    string    nm;
    bit       haveD;
    bit       haveS;
    nm    = (u == 0) ? "dut1" : "dut3";
    haveD = (u == 0) ? (doneQ1.size() != 0) : (doneQ3.size() != 0);
    haveS = (u == 0) ? (strbQ1.size() != 0) : (strbQ3.size() != 0);
    if (dn != 4'b0000) begin
      if (!haveD) begin
        checkOutput({nm, " unexpected done"}, 32'(dn), 32'd0);
      end else begin
        if (u == 0) de = doneQ1.pop_front();
        else        de = doneQ3.pop_front();
        checkOutput({nm, " done vector"}, 32'(dn), 32'(1) << de.idx);
        checkOutput({nm, " rd_data at done"}, 32'(rd), 32'(de.rd));
        checkOutput({nm, " busy during done"}, 32'(bsy), 32'd1);
      end
    end
    if (rRd || rWr) begin
      if (!haveS) begin
        checkOutput({nm, " unexpected strobe"}, {30'd0, rWr, rRd}, 32'd0);
      end else begin
        if (u == 0) se = strbQ1.pop_front();
        else        se = strbQ3.pop_front();
        checkOutput({nm, " strobe kind"}, {30'd0, rWr, rRd}, se.wr ? 32'd2 : 32'd1);
        checkOutput({nm, " ram_addr"}, 32'(rA), 32'(se.a));
        if (se.wr) checkOutput({nm, " ram_wr_data"}, 32'(rWd), 32'(se.d));
        checkOutput({nm, " busy during strobe"}, 32'(bsy), 32'd1);
      end
    end
  endtask

  always @(negedge clk)
    checkDut(0, ifc1.done, ifc1.rd_data, ifc1.busy, ifc1.ram_rd, ifc1.ram_wr,
             ifc1.ram_addr, ifc1.ram_wr_data);

  always @(negedge clk)
    checkDut(1, ifc3.done, ifc3.rd_data, ifc3.busy, ifc3.ram_rd, ifc3.ram_wr,
             ifc3.ram_addr, ifc3.ram_wr_data);

  task automatic checkCleared(input string nm, input logic [3:0] dn, input logic [7:0] rd,
                              input logic bsy, input logic rRd, input logic rWr,
                              input logic [7:0] rA, input logic [7:0] rWd);
    checkOutput({nm, " reset done"},        32'(dn),  32'd0);
    checkOutput({nm, " reset rd_data"},     32'(rd),  32'd0);
    checkOutput({nm, " reset busy"},        32'(bsy), 32'd0);
    checkOutput({nm, " reset strobes"},     {30'd0, rWr, rRd}, 32'd0);
    checkOutput({nm, " reset ram_addr"},    32'(rA),  32'd0);
    checkOutput({nm, " reset ram_wr_data"}, 32'(rWd), 32'd0);
  endtask

  initial begin
    int  n;
    logic seenRd;

    rst1N = 1'b0;
    rst3N = 1'b0;
    for (int u = 0; u < 2; u++) begin
      reqV[u] = '0; weV[u] = '0; addrV[u] = '0; wdataV[u] = '0;
    end

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCleared("dut1", ifc1.done, ifc1.rd_data, ifc1.busy, ifc1.ram_rd, ifc1.ram_wr,
                 ifc1.ram_addr, ifc1.ram_wr_data);
    checkCleared("dut3", ifc3.done, ifc3.rd_data, ifc3.busy, ifc3.ram_rd, ifc3.ram_wr,
                 ifc3.ram_addr, ifc3.ram_wr_data);
    rst1N = 1'b1;
    rst3N = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle busy", 32'(ifc1.busy), 32'd0);
      checkOutput("idle strobes", {30'd0, ifc1.ram_wr, ifc1.ram_rd}, 32'd0);
    end

    // Single write then read on requester 0, address 0x00.
    txn(0, 0, 1'b1, 8'h00, 8'h72, 8'h00, 3);
    txn(0, 0, 1'b0, 8'h00, 8'h00, 8'h72, 4);

    // Uninitialised read, write, read back; rd_data holds through the write.
    txn(0, 0, 1'b0, 8'h01, 8'h00, 8'h00, 4);
    txn(0, 0, 1'b1, 8'h01, 8'hAA, 8'h00, 3);
    txn(0, 0, 1'b0, 8'h01, 8'h00, 8'hAA, 4);
    // Top address passes through untouched.
    txn(0, 3, 1'b1, 8'hFF, 8'hC3, 8'hAA, 3);
    txn(0, 3, 1'b0, 8'hFF, 8'h00, 8'hC3, 4);

    // Re-reset so the pointer is back to NUM_REQ-1 before the contention run.
    @(negedge clk);
    rst1N = 1'b0;
    @(negedge clk);
    checkOutput("mid reset rd_data", 32'(ifc1.rd_data), 32'd0);
    rst1N = 1'b1;

    // All four requesters at once: grants 0,1,2,3, one write per 3 cycles.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) expectTxn(0, i, 1'b1, 8'(i), 8'(8'h10 + i), 8'h00);
    fork
      begin int l; applyStimulus(0, 0, 1'b1, 8'h00, 8'h10, l); checkOutput("rr lat req0", l, 3);  end
      begin int l; applyStimulus(0, 1, 1'b1, 8'h01, 8'h11, l); checkOutput("rr lat req1", l, 6);  end
      begin int l; applyStimulus(0, 2, 1'b1, 8'h02, 8'h12, l); checkOutput("rr lat req2", l, 9);  end
      begin int l; applyStimulus(0, 3, 1'b1, 8'h03, 8'h13, l); checkOutput("rr lat req3", l, 12); end
    join

    // Requester 1 re-requests after each done while requester 2 holds its
    // request: grants alternate 1,2,1,2.
    @(posedge clk);
    #1;
    expectTxn(0, 1, 1'b1, 8'h20, 8'h31, 8'h00);
    expectTxn(0, 2, 1'b0, 8'h02, 8'h00, 8'h12);
    expectTxn(0, 1, 1'b1, 8'h21, 8'h32, 8'h12);
    expectTxn(0, 2, 1'b0, 8'h03, 8'h00, 8'h13);
    fork
      begin
        int l;
        applyStimulus(0, 1, 1'b1, 8'h20, 8'h31, l);
        checkOutput("fair lat req1 first", l, 3);
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 1'b1, 8'h21, 8'h32, l);
        checkOutput("fair lat req1 second", l, 6);
      end
      begin
        int l;
        applyStimulus(0, 2, 1'b0, 8'h02, 8'h00, l);
        checkOutput("fair lat req2 first", l, 7);
        @(posedge clk);
        #1;
        applyStimulus(0, 2, 1'b0, 8'h03, 8'h00, l);
        checkOutput("fair lat req2 second", l, 6);
      end
    join

    // Reset during WAIT on the RD_LATENCY=3 instance.
    txn(1, 0, 1'b1, 8'h05, 8'h5C, 8'h00, 3);
    @(posedge clk);
    #1;
    begin
      strbExp_t se;
      se.wr = 1'b0; se.a = 8'h05; se.d = 8'h00;
      strbQ3.push_back(se);
    end
    weV[1][0]       = 1'b0;
    addrV[1][7:0]   = 8'h05;
    reqV[1][0]      = 1'b1;
    n      = 0;
    seenRd = 1'b0;
    while (!seenRd && n < 20) begin
      @(posedge clk);
      n++;
      seenRd = ifc3.ram_rd;
    end
    checkOutput("dut3 read strobe issued", 32'(seenRd), 32'd1);
    #1;
    rst3N      = 1'b0;
    reqV[1][0] = 1'b0;
    #1;
    checkCleared("dut3 abort", ifc3.done, ifc3.rd_data, ifc3.busy, ifc3.ram_rd, ifc3.ram_wr,
                 ifc3.ram_addr, ifc3.ram_wr_data);
    repeat (3) @(negedge clk);
    rst3N = 1'b1;
    repeat (4) @(negedge clk);
    txn(1, 0, 1'b0, 8'h05, 8'h00, 8'h5C, 6);

    repeat (6) @(posedge clk);
    checkOutput("dut1 done queue drained",   32'(doneQ1.size()), 32'd0);
    checkOutput("dut1 strobe queue drained", 32'(strbQ1.size()), 32'd0);
    checkOutput("dut3 done queue drained",   32'(doneQ3.size()), 32'd0);
    checkOutput("dut3 strobe queue drained", 32'(strbQ3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Hard stop in case a stimulus loop ever stalls past every bound.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no end of test, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8-bit system RAM between NUM_REQ bus masters (flight-control CPU, sensor capture, telemetry, debug).
- Accepts level-held requests with a req/done handshake and grants them in round-robin order.
- Drives the RAM's one-cycle rd/wr strobes, waits out the read latency, and returns captured read data to the winner.
- Sits between the masters and the RAM instance, clocked by clk_system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
RD_LATENCY, 1, clk_system edges from the ram_rd strobe edge until ram_rd_data is valid (1..4)

Ports:
clk_system  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level
we  in  NUM_REQ  per-requester 1=write, 0=read; valid while req high
addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  packed write data, same packing
done  out  NUM_REQ  one-cycle completion pulse to the served requester
rd_data  out  DATA_W  last captured read data, shared by all requesters
busy  out  1  high in any state other than IDLE
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wr_data  out  DATA_W  RAM write data
ram_rd_data  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - done, rd_data, ram_rd, ram_wr, ram_addr, ram_wr_data all 0; busy=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 wins first.
  - Reset asserted mid-transaction aborts it; no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Latch that requester's index, we, addr and wdata; go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ram_addr=latched addr.
  - Write: ram_wr=1, ram_wr_data=latched wdata; next state DONE.
  - Read: ram_rd=1; next state WAIT.
  - Strobes are high for exactly this cycle and 0 in every other state.
  - ram_addr and ram_wr_data hold their values until the next ISSUE.
- WAIT:
  - Down-counter loaded with RD_LATENCY; decrements each cycle.
  - In the last WAIT cycle, capture ram_rd_data into rd_data; go to DONE.
- DONE (1 cycle):
  - done[granted]=1, all other done bits 0.
  - pointer=granted index; next state IDLE.
- Latency from the IDLE sampling edge to the done cycle:
  - Write: 2 cycles.
  - Read: 2+RD_LATENCY cycles.
  - Each transaction also spends 1 IDLE cycle, so back-to-back throughput is one write per 3 cycles and one read per 3+RD_LATENCY cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until it samples done=1.
  - It then deasserts req at that same edge, so req is low in the following IDLE cycle.
  - Payload changes after the grant are ignored, because the payload is latched in IDLE.
  - req dropping after the grant does not cancel the transaction; done still pulses.
- rd_data:
  - Valid in the done cycle of a read; held until the next read capture.
  - Writes never change rd_data.
- Fairness:
  - The served requester becomes lowest priority.
  - With all requesters continuously requesting, grant order is 0,1,2,3,0,…
- Boundaries:
  - Addresses 0x00 and 0xFF pass through unmodified.
  - Simultaneous requests are resolved only by the pointer.
  - A request arriving during busy waits until IDLE.

Test Plan:
1. Reset then idle: reset_n low for 2 cycles, no req -> all outputs 0; after reset, busy=0 and ram_rd/ram_wr never assert.
2. Single write then read, requester 0: write addr 0x00, data 0x72 -> ram_wr high 1 cycle with ram_addr=0x00 and ram_wr_data=0x72, done[0] 2 cycles after the sampling edge. Then read 0x00 -> ram_rd high 1 cycle, done[0] 3 cycles after the sampling edge, rd_data=0x72.
3. Uninitialised read and second write: read 0x01 -> rd_data=0x00. Write 0xAA to 0x01, then read 0x01 -> rd_data=0xAA; rd_data holds 0x00 through the write.
4. Round-robin: all 4 requesters raise req in the same cycle, each writing address=index and data=0x10+index -> grants 0,1,2,3 in order; exactly one done pulse each; RAM contents 0x10..0x13.
5. Fairness under contention: requester 1 re-requests immediately after each done while requester 2 holds req -> grants alternate 1,2,1,2; requester 2 never waits more than one transaction.
6. Reset mid-read: assert reset_n low during WAIT (RD_LATENCY=3 build) -> outputs clear immediately, no done pulse; a fresh request after release completes normally with the correct rd_data.
